// File: rtl/extensor_imediato_fifo.sv
// Immediate-extension unit with a valid/ready handshake and a DEPTH-entry
// result FIFO. Decode pushes an IN_W-bit immediate plus a 2-bit mode, and
// execute pops OUT_W-bit extended values. Only extended results are queued.
module extensor_imediato_fifo #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [IN_W-1:0]            entrada,
  input  logic [1:0]                 modo,
  input  logic                       valido_in,
  output logic                       pronto_in,
  output logic [OUT_W-1:0]           saida,
  output logic                       valido_out,
  input  logic                       pronto_out,
  output logic [$clog2(DEPTH):0]     ocupacao,
  output logic                       erro_modo
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int EXT_W = OUT_W - IN_W;
  // The upper mode only fits when the immediate occupies at most half the word.
  localparam bit UPPER_OK = (OUT_W >= 2 * IN_W);

  typedef enum logic [1:0] {
    MODO_SINAL    = 2'b00,
    MODO_ZERO     = 2'b01,
    MODO_SUPERIOR = 2'b10,
    MODO_DESVIO   = 2'b11
  } modo_t;

  logic [OUT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [OUT_W-1:0] ultimo_q;
  logic [OUT_W-1:0] estendido;
  logic             modo_ilegal;
  logic             vazio, cheio, push, pop;

  assign vazio      = (count == '0);
  assign cheio      = (count == CNT_W'(DEPTH));
  assign pronto_in  = !cheio;
  assign valido_out = !vazio;
  assign push       = valido_in && pronto_in;
  assign pop        = valido_out && pronto_out;
  assign ocupacao   = count;

  // Extension of the incoming immediate, evaluated only for the push path.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    estendido   = {{EXT_W{1'b0}}, entrada};
    modo_ilegal = 1'b0;
    case (modo_t'(modo))
      MODO_SINAL:  estendido = {{EXT_W{entrada[IN_W-1]}}, entrada};
      MODO_ZERO:   estendido = {{EXT_W{1'b0}}, entrada};
      MODO_SUPERIOR: begin
        if (UPPER_OK) begin
          estendido = {entrada, {EXT_W{1'b0}}};
        end else begin
          estendido   = {{EXT_W{1'b0}}, entrada};
          modo_ilegal = 1'b1;
        end
      end
      // Sign-extend to OUT_W-2 bits and append two zeros: same as a full
      // sign extension shifted left by 2 with the top two bits dropped.
      MODO_DESVIO: estendido = {{(EXT_W - 2){entrada[IN_W-1]}}, entrada, 2'b00};
      default:     estendido = {{EXT_W{1'b0}}, entrada};
    endcase
  end

  // Storage write port; contents are don't-care after reset.
  // NOTE: the array has no reset so it can map to plain RAM; occupancy gating hides stale data.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= estendido;
  end

  // Pointers, occupancy, last-popped value and the sticky mode error.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ultimo_q  <= '0;
      erro_modo <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        ultimo_q <= mem[rd_ptr];
      end
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      if (push && modo_ilegal) erro_modo <= 1'b1;
    end
  end

  // Head entry while data is queued; otherwise the last value that left.
  assign saida = vazio ? ultimo_q : mem[rd_ptr];

endmodule

// File: tb/tb_extensor_imediato_fifo.sv
// Directed bench for extensor_imediato_fifo: reset state, all four modes,
// fill/full behaviour, streaming with back-pressure, mid-stream reset and the
// illegal upper-mode flag on a narrow-output instance.
module tb_extensor_imediato_fifo;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] entrada;
  logic [1:0]  modo;
  logic        valido_in;
  logic        pronto_in;
  logic [31:0] saida;
  logic        valido_out;
  logic        pronto_out;
  logic [2:0]  ocupacao;
  logic        erro_modo;

  // Second instance where OUT_W < 2*IN_W, so the upper mode is illegal.
  logic [19:0] n_entrada;
  logic [1:0]  n_modo;
  logic        n_valido_in;
  logic        n_pronto_in;
  logic [31:0] n_saida;
  logic        n_valido_out;
  logic        n_pronto_out;
  logic [1:0]  n_ocupacao;
  logic        n_erro_modo;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  extensor_imediato_fifo #(.IN_W(16), .OUT_W(32), .DEPTH(4)) u_dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .entrada    (entrada),
    .modo       (modo),
    .valido_in  (valido_in),
    .pronto_in  (pronto_in),
    .saida      (saida),
    .valido_out (valido_out),
    .pronto_out (pronto_out),
    .ocupacao   (ocupacao),
    .erro_modo  (erro_modo)
  );

  extensor_imediato_fifo #(.IN_W(20), .OUT_W(32), .DEPTH(2)) u_dut_narrow (
    .clock      (clock),
    .reset_n    (reset_n),
    .entrada    (n_entrada),
    .modo       (n_modo),
    .valido_in  (n_valido_in),
    .pronto_in  (n_pronto_in),
    .saida      (n_saida),
    .valido_out (n_valido_out),
    .pronto_out (n_pronto_out),
    .ocupacao   (n_ocupacao),
    .erro_modo  (n_erro_modo)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] modo_exp [4];
  logic [31:0] fila_exp [4];

  initial begin
    reset_n      = 1'b0;
    entrada      = '0;
    modo         = '0;
    valido_in    = 1'b0;
    pronto_out   = 1'b0;
    n_entrada    = '0;
    n_modo       = '0;
    n_valido_in  = 1'b0;
    n_pronto_out = 1'b0;

    // ---- reset state ----
    #12;
    check("rst_valido_out", 32'(valido_out), 32'd0);
    check("rst_pronto_in",  32'(pronto_in),  32'd1);
    check("rst_ocupacao",   32'(ocupacao),   32'd0);
    check("rst_saida",      saida,           32'h0000_0000);
    check("rst_erro_modo",  32'(erro_modo),  32'd0);
    check("rst_n_erro",     32'(n_erro_modo), 32'd0);
    #1 reset_n = 1'b1;
    step();
    check("idle_valido_out", 32'(valido_out), 32'd0);
    check("idle_saida",      saida,           32'h0000_0000);

    // ---- 0x8001 in each mode, consumer always ready ----
    modo_exp[0] = 32'hFFFF_8001;
    modo_exp[1] = 32'h0000_8001;
    modo_exp[2] = 32'h8001_0000;
    modo_exp[3] = 32'hFFFE_0004;
    pronto_out = 1'b1;
    entrada    = 16'h8001;
    valido_in  = 1'b1;
    for (int m = 0; m < 4; m++) begin
      modo = 2'(m);
      step();
      check($sformatf("modo%0d_saida", m), saida, modo_exp[m]);
      check($sformatf("modo%0d_valido", m), 32'(valido_out), 32'd1);
    end
    valido_in = 1'b0;
    step();
    check("modos_vazio_valido", 32'(valido_out), 32'd0);
    check("modos_vazio_saida",  saida,           32'hFFFE_0004);
    check("modos_vazio_ocup",   32'(ocupacao),   32'd0);
    check("modos_erro",         32'(erro_modo),  32'd0);

    // ---- fill with consumer stalled ----
    pronto_out = 1'b0;
    modo       = 2'b00;
    valido_in  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      entrada = 16'(i);
      step();
      check($sformatf("fill%0d_ocup", i), 32'(ocupacao), 32'(i));
    end
    check("cheio_pronto_in", 32'(pronto_in), 32'd0);
    entrada = 16'h0005;
    step();
    check("cheio_ocup_hold",  32'(ocupacao), 32'd4);
    check("cheio_saida_hold", saida,         32'h0000_0001);

    // ---- full: push request and pop in the same cycle, pop only ----
    pronto_out = 1'b1;
    step();
    check("cheio_pop_ocup",  32'(ocupacao), 32'd3);
    check("cheio_pop_saida", saida,         32'h0000_0002);
    pronto_out = 1'b0;
    step();
    check("cheio_push_ocup", 32'(ocupacao), 32'd4);
    valido_in  = 1'b0;
    pronto_out = 1'b1;
    fila_exp[0] = 32'h0000_0002;
    fila_exp[1] = 32'h0000_0003;
    fila_exp[2] = 32'h0000_0004;
    fila_exp[3] = 32'h0000_0005;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drena%0d_saida", i), saida, fila_exp[i]);
      step();
    end
    check("drena_valido", 32'(valido_out), 32'd0);

    // ---- streaming 12 values, consumer toggling ----
    begin
      int sent = 0;
      int recv = 0;
      int cyc  = 0;
      modo = 2'b01;
      while (recv < 12 && cyc < 200) begin
        pronto_out = cyc[0];
        valido_in  = (sent < 12);
        entrada    = 16'hA100 + 16'(sent);
        if (valido_out && pronto_out) begin
          check($sformatf("stream%0d", recv), saida, 32'h0000_A100 + 32'(recv));
          recv++;
        end
        if (valido_in && pronto_in) sent++;
        step();
        cyc++;
      end
      check("stream_recebidos", 32'(recv), 32'd12);
      valido_in = 1'b0;
      check("stream_ocup_fim", 32'(ocupacao), 32'd0);
    end

    // ---- mid-stream asynchronous reset ----
    pronto_out = 1'b0;
    modo       = 2'b00;
    valido_in  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      entrada = 16'h7FF0 + 16'(i);
      step();
    end
    valido_in = 1'b0;
    check("pre_rst_ocup", 32'(ocupacao), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valido_out", 32'(valido_out), 32'd0);
    check("arst_ocup",       32'(ocupacao),   32'd0);
    check("arst_pronto_in",  32'(pronto_in),  32'd1);
    check("arst_saida",      saida,           32'h0000_0000);
    #2 reset_n = 1'b1;
    entrada   = 16'h1234;
    modo      = 2'b11;
    valido_in = 1'b1;
    step();
    valido_in = 1'b0;
    check("pos_rst_saida",  saida,           32'h0000_48D0);
    check("pos_rst_valido", 32'(valido_out), 32'd1);
    check("pos_rst_ocup",   32'(ocupacao),   32'd1);

    // ---- illegal upper mode on the narrow instance ----
    n_entrada   = 20'h80001;
    n_modo      = 2'b10;
    n_valido_in = 1'b1;
    step();
    n_valido_in = 1'b0;
    check("narrow_saida", n_saida,            32'h0008_0001);
    check("narrow_erro",  32'(n_erro_modo),   32'd1);
    n_pronto_out = 1'b1;
    step();
    check("narrow_erro_sticky", 32'(n_erro_modo), 32'd1);
    check("wide_erro_clear",    32'(erro_modo),   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
